// File: rtl/phase_driver_if.sv
// Handshake bundle for one motor phase: duty/tri-state request in, gate enables out.
interface phase_driver_if #(
  parameter int W = 8
);
  logic [W-1:0] duty_cycle;
  logic         high_z;
  logic         pwm_high;
  logic         pwm_low;

  modport master (output duty_cycle, high_z, input  pwm_high, pwm_low);
  modport slave  (input  duty_cycle, high_z, output pwm_high, pwm_low);
endinterface

// File: rtl/phase_driver.sv
// Half-bridge PWM driver: complementary high/low gate enables with dead time
// around each transition and a both-off override.
module phase_driver #(
  parameter int DUTY_CYCLE_WIDTH = 8,
  parameter int DEAD_TIME        = 2
) (
  input  logic          clock,
  input  logic          reset,
  phase_driver_if.slave pif
);
  localparam int W = DUTY_CYCLE_WIDTH;
  localparam logic [W-1:0] DT     = W'(DEAD_TIME);
  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] cnt;
  logic [W-1:0] d;
  logic [W:0]   lo_start;
  logic         hi_nxt, lo_nxt;

  // Low start is kept at W+1 bits so a late edge pushes it past the period.
  assign lo_start = {1'b0, d} + {1'b0, DT};

  always_comb begin
    hi_nxt = 1'b0;
    lo_nxt = 1'b0;
    if (!pif.high_z) begin
      if (d == '0) begin
        lo_nxt = 1'b1;
      end else begin
        hi_nxt = (cnt >= DT) && (cnt < d);
        lo_nxt = ({1'b0, cnt} >= lo_start);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt          <= '0;
      d            <= '0;
      pif.pwm_high <= 1'b0;
      pif.pwm_low  <= 1'b0;
    end else begin
      cnt          <= cnt + 1'b1;
      if (cnt == CNT_MAX) d <= pif.duty_cycle;
      pif.pwm_high <= hi_nxt;
      pif.pwm_low  <= lo_nxt;
    end
  end
endmodule

// File: tb/tb_phase_driver.sv
// Directed bench for phase_driver; a cycle model pushes expected outputs to a
// scoreboard queue that is popped and checked one cycle later.
module tb_phase_driver;
  localparam int W  = 8;
  localparam int DT = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  phase_driver_if #(.W(W)) pif ();
  phase_driver #(.DUTY_CYCLE_WIDTH(W), .DEAD_TIME(DT)) dut (
    .clock (clock),
    .reset (reset),
    .pif   (pif.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] m_cnt;
  logic [W-1:0] m_d;
  logic [1:0]   exp_q[$];
  int n_hi, n_lo, n_off, n_both;

  function automatic logic [1:0] model_out(logic [W-1:0] c, logic [W-1:0] dd, logic hz);
    int ci, di;
    logic h, l;
    ci = int'(c);
    di = int'(dd);
    if (hz)      return 2'b00;
    if (di == 0) return 2'b01;
    h = (ci >= DT) && (ci < di);
    l = (ci >= di + DT) && (ci <= (1 << W) - 1);
    return {h, l};
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    logic [1:0] e;
    e = reset ? 2'b00 : model_out(m_cnt, m_d, pif.high_z);
    exp_q.push_back(e);
    if (reset) begin
      m_cnt = '0;
      m_d   = '0;
    end else begin
      if (m_cnt == {W{1'b1}}) m_d = pif.duty_cycle;
      m_cnt = m_cnt + 1'b1;
    end
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    chk("pwm_high", int'(pif.pwm_high), int'(e[1]));
    chk("pwm_low",  int'(pif.pwm_low),  int'(e[0]));
    n_hi   += int'(pif.pwm_high);
    n_lo   += int'(pif.pwm_low);
    n_off  += int'(!pif.pwm_high && !pif.pwm_low);
    n_both += int'(pif.pwm_high && pif.pwm_low);
  endtask

  task automatic clr();
    n_hi = 0; n_lo = 0; n_off = 0; n_both = 0;
  endtask

  task automatic run_to(input int c);
    while (int'(m_cnt) != c) step();
  endtask

  // One full period starting at cnt=0, then compare the per-period totals.
  task automatic period(input string tag, input int ehi, input int elo, input int eoff);
    run_to(0);
    clr();
    repeat (1 << W) step();
    chk({tag, "_hi_clocks"},  n_hi,   ehi);
    chk({tag, "_lo_clocks"},  n_lo,   elo);
    chk({tag, "_off_clocks"}, n_off,  eoff);
    chk({tag, "_overlap"},    n_both, 0);
  endtask

  initial begin
    reset          = 1'b1;
    pif.duty_cycle = 8'h10;
    pif.high_z     = 1'b0;
    m_cnt = '0;
    m_d   = '0;
    clr();

    repeat (3) step();
    chk("reset_off", n_hi + n_lo, 0);
    reset = 1'b0;

    // First period after reset: D still 0, low held on.
    period("first", 0, 256, 0);
    period("steady", 14, 238, 4);

    pif.duty_cycle = 8'h02;
    period("to02", 14, 238, 4);
    period("dead_swallow", 0, 252, 4);

    pif.duty_cycle = 8'h00;
    period("to00", 0, 252, 4);
    period("zero", 0, 256, 0);

    pif.duty_cycle = 8'hFF;
    period("to_ff", 0, 256, 0);
    period("full", 253, 0, 3);

    // Mid-period change from 0x10 to 0x80 only takes effect next period.
    pif.duty_cycle = 8'h10;
    period("to10", 253, 0, 3);
    run_to(0);
    clr();
    run_to(8'h40);
    pif.duty_cycle = 8'h80;
    run_to(0);
    chk("mid_cur_hi", n_hi, 14);
    chk("mid_cur_lo", n_lo, 238);
    period("mid_next", 126, 126, 4);

    // Tri-state override while D=0x10.
    pif.duty_cycle = 8'h10;
    period("to10b", 126, 126, 4);
    run_to(8'h08);
    pif.high_z = 1'b1;
    step();
    chk("hz_hi_after", int'(pif.pwm_high), 0);
    chk("hz_lo_after", int'(pif.pwm_low),  0);
    clr();
    run_to(8'h30);
    chk("hz_hold", n_hi + n_lo, 0);
    pif.high_z = 1'b0;
    step();
    chk("hz_rel_lo", int'(pif.pwm_low),  1);
    chk("hz_rel_hi", int'(pif.pwm_high), 0);

    // Reset in the middle of a period.
    run_to(8'h20);
    reset = 1'b1;
    step();
    chk("midreset_hi", int'(pif.pwm_high), 0);
    chk("midreset_lo", int'(pif.pwm_low),  0);
    reset = 1'b0;
    period("after_midreset", 0, 256, 0);
    period("after_midreset2", 14, 238, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
